// File: rtl/match_ctrl.sv
// rtl/match_ctrl.sv - two-player ball game round sequencer, loss scoring and score display scan
module match_ctrl #(
    parameter int WIN_SCORE = 5,
    parameter int SERVE_CYC = 1024,
    parameter int SCAN_DIV  = 512,
    parameter int BLINK_DIV = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       lose1,
    input  logic       lose2,
    output logic       ball_en,
    output logic       serve_dir,
    output logic [3:0] loss1,
    output logic [3:0] loss2,
    output logic [1:0] winner,
    output logic [1:0] state,
    output logic [3:0] digit_val,
    output logic [3:0] select
);

    localparam int SERVE_W = $clog2(SERVE_CYC);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_CYC - 1);
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [3:0]         WIN        = 4'(WIN_SCORE);

    localparam logic [3:0] DIG_DASH  = 4'd10;
    localparam logic [3:0] DIG_SEP   = 4'd11;
    localparam logic [3:0] DIG_BLANK = 4'd15;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SERVE = 2'b01,
        S_PLAY  = 2'b10,
        S_OVER  = 2'b11
    } state_t;

    // Input synchronisers, bit order {start, lose1, lose2}
    logic [2:0] sync1_q, sync2_q, sync3_q;
    logic [2:0] rise;
    logic       start_rise, lose1_rise, lose2_rise;

    // Round FSM state and registered outputs
    state_t               state_q;
    logic [SERVE_W-1:0]   serve_cnt_q;
    logic [3:0]           loss1_q, loss2_q;
    logic [3:0]           loss1_d, loss2_d;
    logic                 full1, full2;
    logic [1:0]           winner_q;
    logic                 ball_en_q;
    logic                 serve_dir_q;

    // Display scan
    logic [SCAN_W-1:0]    presc_q;
    logic                 scan_tick;
    logic [1:0]           idx_q, idx_d;
    logic [3:0]           select_q, select_d;
    logic [3:0]           digit_q, digit_d;
    logic [BLINK_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                 blink_q, blink_d;

    // Three-flop chain per async input: two to resolve metastability, one for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
            sync3_q <= 3'b000;
        end else begin
            sync1_q <= {start, lose1, lose2};
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    assign rise       = sync2_q & ~sync3_q;
    assign start_rise = rise[2];
    assign lose1_rise = rise[1];
    assign lose2_rise = rise[0];

    // Post-increment loss counts, saturating at the winning score
    always_comb begin
        loss1_d = loss1_q;
        loss2_d = loss2_q;
        if (lose1_rise && (loss1_q != WIN)) begin
            loss1_d = loss1_q + 4'd1;
        end
        if (lose2_rise && (loss2_q != WIN)) begin
            loss2_d = loss2_q + 4'd1;
        end
    end

    assign full1 = (loss1_d == WIN);
    assign full2 = (loss2_d == WIN);

    // Round sequencing: idle -> serve hold -> play -> serve/over, with scoring in play
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            serve_cnt_q <= '0;
            loss1_q     <= 4'd0;
            loss2_q     <= 4'd0;
            winner_q    <= 2'b00;
            ball_en_q   <= 1'b0;
            serve_dir_q <= 1'b0;
        end else begin
            ball_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_rise) begin
                        state_q     <= S_SERVE;
                        serve_cnt_q <= '0;
                    end
                end
                S_SERVE: begin
                    if (serve_cnt_q == SERVE_LAST) begin
                        state_q     <= S_PLAY;
                        serve_cnt_q <= '0;
                    end else begin
                        serve_cnt_q <= serve_cnt_q + SERVE_W'(1);
                    end
                end
                S_PLAY: begin
                    if (lose1_rise || lose2_rise) begin
                        loss1_q <= loss1_d;
                        loss2_q <= loss2_d;
                        // A simultaneous double miss leaves the serve side alone
                        if (lose1_rise && !lose2_rise) begin
                            serve_dir_q <= 1'b0;
                        end else if (lose2_rise && !lose1_rise) begin
                            serve_dir_q <= 1'b1;
                        end
                        if (full1 || full2) begin
                            state_q  <= S_OVER;
                            winner_q <= {full1, full2};
                        end else begin
                            state_q     <= S_SERVE;
                            serve_cnt_q <= '0;
                        end
                    end else begin
                        ball_en_q <= 1'b1;
                    end
                end
                S_OVER: begin
                    if (start_rise) begin
                        state_q     <= S_SERVE;
                        serve_cnt_q <= '0;
                        loss1_q     <= 4'd0;
                        loss2_q     <= 4'd0;
                        winner_q    <= 2'b00;
                        serve_dir_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Free-running digit-slot prescaler, tick on the terminal count
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
        end else if (scan_tick) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + SCAN_W'(1);
        end
    end

    assign scan_tick = (presc_q == SCAN_LAST);

    // Blink phase only runs while the match is over; any other state holds it cleared
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        if (state_q != S_OVER) begin
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (scan_tick) begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end
    end

    // Next digit slot contents, using the blink phase that takes effect on this tick
    always_comb begin
        idx_d    = idx_q + 2'd1;
        select_d = 4'b1111;
        digit_d  = 4'd0;
        case (idx_d)
            2'd0: begin
                select_d = 4'b0111;
                digit_d  = (blink_d && winner_q[0]) ? DIG_BLANK : loss1_q;
            end
            2'd1: begin
                select_d = 4'b1011;
                digit_d  = DIG_DASH;
            end
            2'd2: begin
                select_d = 4'b1101;
                digit_d  = DIG_SEP;
            end
            default: begin
                select_d = 4'b1110;
                digit_d  = (blink_d && winner_q[1]) ? DIG_BLANK : loss2_q;
            end
        endcase
    end

    // Scan index, blink phase and display outputs; display only changes on a tick
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= 2'd0;
            select_q    <= 4'b1111;
            digit_q     <= 4'd0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            if (scan_tick) begin
                idx_q    <= idx_d;
                select_q <= select_d;
                digit_q  <= digit_d;
            end
        end
    end

    assign ball_en   = ball_en_q;
    assign serve_dir = serve_dir_q;
    assign loss1     = loss1_q;
    assign loss2     = loss2_q;
    assign winner    = winner_q;
    assign state     = state_q;
    assign digit_val = digit_q;
    assign select    = select_q;

endmodule

// File: tb/tb_match_ctrl.sv
// tb/tb_match_ctrl.sv - randomized self-checking bench for match_ctrl against a game-rule model
module tb_match_ctrl;

    localparam int WIN_SCORE = 5;
    localparam int SERVE_CYC = 16;
    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       lose1 = 1'b0;
    logic       lose2 = 1'b0;
    logic       ball_en, serve_dir;
    logic [3:0] loss1, loss2, digit_val, select;
    logic [1:0] winner, state;

    int checks = 0;
    int errors = 0;

    match_ctrl #(
        .WIN_SCORE(WIN_SCORE),
        .SERVE_CYC(SERVE_CYC),
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .lose1    (lose1),
        .lose2    (lose2),
        .ball_en  (ball_en),
        .serve_dir(serve_dir),
        .loss1    (loss1),
        .loss2    (loss2),
        .winner   (winner),
        .state    (state),
        .digit_val(digit_val),
        .select   (select)
    );

    always #5 clk = ~clk;

    // Reference model: game rules evaluated per clock edge from input history and edge counts
    int n, ticks, oticks, m_sstart;
    int m_state, m_l1, m_l2, m_win, m_dir, m_ball, m_sel, m_dv;
    bit sh[3], ah[3], bh[3];

    always @(posedge clk) begin : model
        bit sr, r1, r2, blink;
        int idx, val;
        if (rst) begin
            n = 0; ticks = 0; oticks = 0; m_sstart = 0;
            m_state = 0; m_l1 = 0; m_l2 = 0; m_win = 0; m_dir = 0; m_ball = 0;
            m_sel = 15; m_dv = 0;
            for (int i = 0; i < 3; i++) begin sh[i] = 0; ah[i] = 0; bh[i] = 0; end
        end else begin
            n++;
            sr = sh[1] && !sh[2];
            r1 = ah[1] && !ah[2];
            r2 = bh[1] && !bh[2];
            if (m_state != 3) oticks = 0;
            else if (n % SCAN_DIV == 0) oticks++;
            if (n % SCAN_DIV == 0) begin
                ticks++;
                blink = (m_state == 3) && ((oticks / BLINK_DIV) % 2 == 1);
                idx = ticks % 4;
                case (idx)
                    0: val = m_l1;
                    1: val = 10;
                    2: val = 11;
                    default: val = m_l2;
                endcase
                if (blink && idx == 0 && (m_win == 1 || m_win == 3)) val = 15;
                if (blink && idx == 3 && (m_win == 2 || m_win == 3)) val = 15;
                m_sel = 15 ^ (8 >> idx);
                m_dv = val;
            end
            m_ball = 0;
            case (m_state)
                0: if (sr) begin m_state = 1; m_sstart = n; end
                1: if (n - m_sstart == SERVE_CYC) m_state = 2;
                2: begin
                    if (r1 || r2) begin
                        if (r1) m_l1 = (m_l1 + 1 > WIN_SCORE) ? WIN_SCORE : m_l1 + 1;
                        if (r2) m_l2 = (m_l2 + 1 > WIN_SCORE) ? WIN_SCORE : m_l2 + 1;
                        if (r1 && !r2) m_dir = 0;
                        if (r2 && !r1) m_dir = 1;
                        if (m_l1 == WIN_SCORE || m_l2 == WIN_SCORE) begin
                            m_state = 3;
                            m_win = (m_l1 == WIN_SCORE ? 2 : 0) + (m_l2 == WIN_SCORE ? 1 : 0);
                        end else begin
                            m_state = 1; m_sstart = n;
                        end
                    end else begin
                        m_ball = 1;
                    end
                end
                default: if (sr) begin
                    m_l1 = 0; m_l2 = 0; m_win = 0; m_dir = 0; m_state = 1; m_sstart = n;
                end
            endcase
            sh[2] = sh[1]; sh[1] = sh[0]; sh[0] = start;
            ah[2] = ah[1]; ah[1] = ah[0]; ah[0] = lose1;
            bh[2] = bh[1]; bh[1] = bh[0]; bh[0] = lose2;
        end
    end

    wire  [21:0] dut_vec = {state, loss1, loss2, winner, ball_en, serve_dir, select, digit_val};
    logic [21:0] mod_vec;
    logic [21:0] last_got, last_exp;

    always_comb mod_vec = {m_state[1:0], m_l1[3:0], m_l2[3:0], m_win[1:0], m_ball[0], m_dir[0],
                           m_sel[3:0], m_dv[3:0]};

    // Advance cycles, tallying cycles where the DUT outputs differ from the model
    task automatic step(input int cycles, inout int bad);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (dut_vec !== mod_vec) begin
                bad++;
                last_got = dut_vec;
                last_exp = mod_vec;
            end
        end
    endtask

    task automatic pulse(input int which, input int width, inout int bad);
        lose1 = which[0];
        lose2 = which[1];
        start = which[2];
        step(width, bad);
        lose1 = 1'b0;
        lose2 = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_play(input int budget, output bit ok, inout int bad);
        ok = (m_state == 2);
        for (int i = 0; i < budget && !ok; i++) begin
            step(1, bad);
            ok = (m_state == 2);
        end
    endtask

    task automatic round(input int which, output bit ok, inout int bad);
        wait_play(SERVE_CYC + 8, ok, bad);
        step($urandom_range(0, 4), bad);
        pulse(which, $urandom_range(1, 4), bad);
        step(3, bad);
    endtask

    task automatic test_reset;
        int bad = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== {2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 4'b1111, 4'd0}) begin
            errors++;
            $display("FAIL reset_state: got %h expected %h", dut_vec,
                     {2'b00, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 4'b1111, 4'd0});
        end
        rst = 1'b0;
        step(SCAN_DIV - 1, bad);
        checks++;
        if (select !== 4'b1111) begin
            errors++;
            $display("FAIL pre_first_tick: select=%b expected 1111", select);
        end
        step(1, bad);
        checks++;
        if (select !== 4'b1011 || digit_val !== 4'd10) begin
            errors++;
            $display("FAIL first_tick: select=%b digit=%0d expected 1011/10", select, digit_val);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL trace_reset: %0d cycles, last dut=%h model=%h", bad, last_got, last_exp);
        end
    endtask

    task automatic test_start_serve;
        int bad = 0;
        int hold;
        step($urandom_range(0, 7), bad);
        hold = $urandom_range(1, 6);
        start = 1'b1;
        for (int i = 0; i < SERVE_CYC + 4; i++) begin
            if (i == hold) start = 1'b0;
            step(1, bad);
            if (i == 1) begin
                checks++;
                if (state !== 2'b00) begin
                    errors++;
                    $display("FAIL serve_early: state=%b expected 00", state);
                end
            end
            if (i == 2) begin
                checks++;
                if (state !== 2'b01 || ball_en !== 1'b0) begin
                    errors++;
                    $display("FAIL serve_entry: state=%b ball_en=%b expected 01/0", state, ball_en);
                end
            end
            if (i == SERVE_CYC + 1) begin
                checks++;
                if (state !== 2'b01) begin
                    errors++;
                    $display("FAIL serve_length: state=%b expected 01", state);
                end
            end
            if (i == SERVE_CYC + 2) begin
                checks++;
                if (state !== 2'b10 || ball_en !== 1'b0) begin
                    errors++;
                    $display("FAIL play_entry: state=%b ball_en=%b expected 10/0", state, ball_en);
                end
            end
            if (i == SERVE_CYC + 3) begin
                checks++;
                if (ball_en !== 1'b1) begin
                    errors++;
                    $display("FAIL ball_en_late: ball_en=%b expected 1", ball_en);
                end
            end
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL trace_serve: %0d cycles, last dut=%h model=%h", bad, last_got, last_exp);
        end
    endtask

    task automatic test_lose_held;
        int bad = 0;
        lose2 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1, bad);
            if (i == 1) begin
                checks++;
                if (loss2 !== 4'd0) begin
                    errors++;
                    $display("FAIL lose_early: loss2=%0d expected 0", loss2);
                end
            end
            if (i == 2) begin
                checks++;
                if (loss2 !== 4'd1 || state !== 2'b01 || serve_dir !== 1'b1) begin
                    errors++;
                    $display("FAIL lose_score: loss2=%0d state=%b dir=%b expected 1/01/1",
                             loss2, state, serve_dir);
                end
            end
        end
        lose2 = 1'b0;
        step(2, bad);
        checks++;
        if (loss2 !== 4'd1 || loss1 !== 4'd0) begin
            errors++;
            $display("FAIL lose_held_once: loss1=%0d loss2=%0d expected 0/1", loss1, loss2);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL trace_lose_held: %0d cycles, last dut=%h model=%h", bad, last_got, last_exp);
        end
    endtask

    task automatic test_p1_loses;
        int bad = 0;
        int n15 = 0;
        int nl = 0;
        bit ok;
        for (int r = 0; r < WIN_SCORE; r++) begin
            round(1, ok, bad);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL p1_round_timeout: round %0d state=%b expected 10", r, state);
            end
        end
        checks++;
        if (loss1 !== 4'd5 || state !== 2'b11 || winner !== 2'b10 || ball_en !== 1'b0) begin
            errors++;
            $display("FAIL p1_over: loss1=%0d state=%b winner=%b ball_en=%b expected 5/11/10/0",
                     loss1, state, winner, ball_en);
        end
        for (int k = 0; k < 3; k++) begin
            pulse(1, $urandom_range(1, 3), bad);
            step($urandom_range(2, 6), bad);
        end
        checks++;
        if (loss1 !== 4'd5 || state !== 2'b11) begin
            errors++;
            $display("FAIL over_saturate: loss1=%0d state=%b expected 5/11", loss1, state);
        end
        for (int i = 0; i < 200; i++) begin
            step(1, bad);
            if (select === 4'b1110) begin
                if (digit_val === 4'd15) n15++;
                else if (digit_val === loss2) nl++;
            end
        end
        checks++;
        if (n15 == 0 || nl == 0) begin
            errors++;
            $display("FAIL blink_idx3: blank=%0d score=%0d cycles, expected both nonzero", n15, nl);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL trace_p1: %0d cycles, last dut=%h model=%h", bad, last_got, last_exp);
        end
    endtask

    task automatic test_draw;
        int bad = 0;
        int ord[8];
        int j, t;
        bit ok, dir;
        pulse(4, $urandom_range(1, 3), bad);
        step(4, bad);
        for (int i = 0; i < 8; i++) ord[i] = (i < 4) ? 1 : 2;
        for (int i = 7; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < 8; i++) begin
            round(ord[i], ok, bad);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL draw_round_timeout: round %0d state=%b expected 10", i, state);
            end
        end
        checks++;
        if (loss1 !== 4'd4 || loss2 !== 4'd4) begin
            errors++;
            $display("FAIL draw_setup: loss1=%0d loss2=%0d expected 4/4", loss1, loss2);
        end
        wait_play(SERVE_CYC + 8, ok, bad);
        dir = serve_dir;
        pulse(3, $urandom_range(1, 3), bad);
        step(3, bad);
        checks++;
        if (loss1 !== 4'd5 || loss2 !== 4'd5 || winner !== 2'b11 || state !== 2'b11 || serve_dir !== dir) begin
            errors++;
            $display("FAIL draw_end: loss=%0d/%0d winner=%b state=%b dir=%b expected 5/5/11/11/%b",
                     loss1, loss2, winner, state, serve_dir, dir);
        end
        step(80, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL trace_draw: %0d cycles, last dut=%h model=%h", bad, last_got, last_exp);
        end
    endtask

    task automatic test_reset_mid_play;
        int bad = 0;
        bit ok;
        pulse(4, 1, bad);
        step(3, bad);
        for (int r = 0; r < 3; r++) begin
            round(1, ok, bad);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rst_round_timeout: round %0d state=%b expected 10", r, state);
            end
        end
        wait_play(SERVE_CYC + 8, ok, bad);
        step($urandom_range(1, 3), bad);
        checks++;
        if (loss1 !== 4'd3 || state !== 2'b10) begin
            errors++;
            $display("FAIL rst_setup: loss1=%0d state=%b expected 3/10", loss1, state);
        end
        rst = 1'b1;
        step(1, bad);
        rst = 1'b0;
        checks++;
        if (state !== 2'b00 || loss1 !== 4'd0 || ball_en !== 1'b0 || select !== 4'b1111 || winner !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_play: state=%b loss1=%0d ball_en=%b select=%b winner=%b expected 00/0/0/1111/00",
                     state, loss1, ball_en, select, winner);
        end
        pulse(1, 2, bad);
        step(4, bad);
        checks++;
        if (loss1 !== 4'd0 || state !== 2'b00) begin
            errors++;
            $display("FAIL idle_lose: loss1=%0d state=%b expected 0/00", loss1, state);
        end
        pulse(4, 1, bad);
        step(3, bad);
        pulse(1, 2, bad);
        step(4, bad);
        checks++;
        if (loss1 !== 4'd0 || state !== 2'b01) begin
            errors++;
            $display("FAIL serve_lose: loss1=%0d state=%b expected 0/01", loss1, state);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL trace_rst_mid: %0d cycles, last dut=%h model=%h", bad, last_got, last_exp);
        end
    endtask

    task automatic test_random_play;
        int bad = 0;
        bit ok;
        for (int r = 0; r < 40 && m_state != 3; r++) begin
            round($urandom_range(1, 7), ok, bad);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rand_round_timeout: round %0d state=%b expected 10", r, state);
            end
        end
        checks++;
        if (state !== 2'b11 || winner !== {loss1 == 4'd5, loss2 == 4'd5}) begin
            errors++;
            $display("FAIL rand_over: state=%b winner=%b loss=%0d/%0d expected 11 and winner from full counts",
                     state, winner, loss1, loss2);
        end
        step(60, bad);
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL trace_random: %0d cycles, last dut=%h model=%h", bad, last_got, last_exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_start_serve();
        test_lose_held();
        test_p1_loses();
        test_draw();
        test_reset_mid_play();
        test_random_play();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/match_ctrl.md
Name: match_ctrl

Overview:
Game-sequencing controller for the two-player ball game. It synchronises the raw lose1/lose2 events from the ball logic and keeps both loss counters. A round FSM (idle/serve/play/over) gates ball motion and detects the match end. It also time-multiplexes the four score digits onto one digit value and select bus for the shared 7-segment decoder.

Parameters:
WIN_SCORE, 5, loss count that ends the match (1..9)
SERVE_CYC, 1024, clk cycles ball is held in SERVE before play resumes (>=2)
SCAN_DIV, 512, clk cycles per display digit slot (>=2)
BLINK_DIV, 64, scan ticks per blink half-period in OVER (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
start  in  1  start/restart button level, assumed debounced, async to clk
lose1  in  1  player-1 missed ball, level/pulse, async to clk
lose2  in  1  player-2 missed ball, level/pulse, async to clk
ball_en  out  1  ball motion enable, high only in PLAY
serve_dir  out  1  0 = serve toward player 1, 1 = toward player 2
loss1  out  4  player-1 loss count, binary 0..WIN_SCORE
loss2  out  4  player-2 loss count, binary 0..WIN_SCORE
winner  out  2  00 none, 01 player 1, 10 player 2, 11 draw
state  out  2  00 IDLE, 01 SERVE, 10 PLAY, 11 OVER
digit_val  out  4  value for the decoder: 0-9 digit, 10 '-', 11 separator, 15 blank
select  out  4  active-low digit enable, one-hot-zero

Behaviour:
- Reset, sampled at a clk edge, wins over all other logic. State IDLE, loss1=loss2=0, winner=00, ball_en=0, serve_dir=0, select=1111, digit_val=0, scan index 0, all counters 0, synchroniser flops 0.
- start, lose1 and lose2 each pass through a 2-flop synchroniser and a 3rd flop. rise = s2 & ~s3. An input first sampled high at edge N acts at edge N+2. Only rising edges count. A held level counts once.
- IDLE: ball_en=0. start rise -> SERVE, serve counter cleared.
- SERVE: ball_en=0. Counter runs 0..SERVE_CYC-1, then -> PLAY (SERVE lasts exactly SERVE_CYC cycles). lose rises are ignored.
- PLAY: ball_en=1 (registered, asserted the cycle after entry).
  - lose1 rise: loss1+1, serve_dir=0. lose2 rise: loss2+1, serve_dir=1.
  - Both in the same cycle: both counters increment and serve_dir is unchanged.
  - Counters saturate at WIN_SCORE and never wrap.
  - Next state after any lose rise, evaluated on the post-increment values: any counter == WIN_SCORE -> OVER, otherwise -> SERVE.
- OVER: ball_en=0. winner is set at entry and held: loss1 full -> 10, loss2 full -> 01, both full -> 11. lose rises are ignored. start rise -> clear counters and winner, go to SERVE, serve_dir=0.
- start rises in SERVE or PLAY are ignored.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1 and emits a one-cycle tick at the terminal count. It runs in every state.
  - On a tick, the scan index advances 0->1->2->3->0. select and digit_val are registered on that same edge for the new index:
    - idx0: select 0111, digit_val loss1
    - idx1: select 1011, digit_val 10
    - idx2: select 1101, digit_val 11
    - idx3: select 1110, digit_val loss2
  - The first tick after reset shows idx1. Outputs hold between ticks.
- Blink in OVER:
  - The blink bit toggles every BLINK_DIV ticks. It is cleared on reset and on entry to OVER.
  - While blink=1, the winning player's digit shows 15 (winner 01 -> idx0, 10 -> idx3, 11 -> both).
- Score changes reach digit_val at the next tick that selects that digit. No mid-slot update.

Test Plan:
- rst held 3 cycles, then released -> state=00, loss1=loss2=0, select=1111, ball_en=0; after SCAN_DIV cycles select=1011, digit_val=10.
- start pulse -> SERVE 2 cycles later; after exactly SERVE_CYC cycles state=10, ball_en=1 one cycle later.
- In PLAY, lose2 held high 20 cycles -> loss2=1 exactly 2 cycles after first sample, one increment only, serve_dir=1, state=01.
- Five lose1 rounds -> loss1=5, state=11, winner=10, ball_en=0; further lose1 pulses leave loss1=5; idx3 alternates 15/loss2 every BLINK_DIV ticks.
- With loss1=4 and loss2=4, lose1 and lose2 rise on the same edge -> both 5, winner=11, serve_dir unchanged.
- rst asserted mid-PLAY with loss1=3 -> next cycle state=00, loss1=0, ball_en=0, select=1111; lose1 pulses in IDLE/SERVE don't change counts.
